rob_commit_wide: RTL

ROB_COMMIT_WIDE -- requirements
Module: rob_commit_wide

---
 rtl/rob_commit_wide.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rob_commit_wide.sv
// Reorder buffer with multi-slot in-order commit, retirement RAT and exception flush.
// Optional statistics counters are enabled by defining ROB_COMMIT_STATS_EN.
module rob_commit_wide #(
    parameter int COMMIT_WIDTH = 2,
    parameter int ROB_AW       = 4,
    parameter int ARCH_AW      = 5,
    parameter int PHYS_AW      = 6
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              FREEZE,
    input  logic                              push_req,
    input  logic                              push_hasdst,
    input  logic [ARCH_AW-1:0]                push_arch,
    input  logic [PHYS_AW-1:0]                push_newp,
    input  logic [PHYS_AW-1:0]                push_oldp,
    output logic [ROB_AW-1:0]                 push_tag,
    output logic                              full,
    output logic                              empty,
    input  logic                              cpl_req,
    input  logic [ROB_AW-1:0]                 cpl_idx,
    input  logic                              cpl_exc,
    output logic [COMMIT_WIDTH-1:0]           rel_valid,
    output logic [COMMIT_WIDTH*PHYS_AW-1:0]   rel_phys,
    output logic [2:0]                        com_count,
    output logic                              flush_out,
    output logic                              copy_retrat,
    output logic [(2**ARCH_AW)*PHYS_AW-1:0]   retrat_flat
`ifdef ROB_COMMIT_STATS_EN
    ,
    output logic [31:0]                       stat_commits,
    output logic [15:0]                       stat_exc
`endif
);

    localparam int DEPTH = 2 ** ROB_AW;
    localparam int NARCH = 2 ** ARCH_AW;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t              state;
    logic [ROB_AW-1:0]   head, tail;
    logic [ROB_AW:0]     count;

    logic                fin_q    [DEPTH];
    logic                exc_q    [DEPTH];
    logic                hasdst_q [DEPTH];
    logic [ARCH_AW-1:0]  arch_q   [DEPTH];
    logic [PHYS_AW-1:0]  newp_q   [DEPTH];
    logic [PHYS_AW-1:0]  oldp_q   [DEPTH];
    logic [PHYS_AW-1:0]  retrat   [NARCH];

    logic [ROB_AW-1:0]       slot_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] retire;
    logic [2:0]              ret_n;
    logic                    chain;
    logic                    head_exc;
    logic                    push_ok;
    logic                    cpl_ok;
    logic [ROB_AW-1:0]       cpl_off;

    assign push_tag = tail;
    assign empty    = (count == '0);
    assign full     = (count == (ROB_AW+1)'(DEPTH)) || (state == FLUSH);

    for (genvar g = 0; g < NARCH; g++) begin : g_rat
        assign retrat_flat[g*PHYS_AW +: PHYS_AW] = retrat[g];
    end

    // Retirement is an unbroken prefix of finished, non-excepting entries from head.
    always_comb begin
        retire = '0;
        ret_n  = 3'd0;
        chain  = (state == RUN) && !FREEZE;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slot_idx[k] = head + ROB_AW'(k);
            if (chain && ((ROB_AW+1)'(k) < count) && fin_q[slot_idx[k]] && !exc_q[slot_idx[k]]) begin
                retire[k] = 1'b1;
                ret_n     = ret_n + 3'd1;
            end else begin
                chain = 1'b0;
            end
        end
    end

    assign head_exc = (state == RUN) && !FREEZE && (count != '0) && fin_q[head] && exc_q[head];
    assign push_ok  = push_req && !full && (state == RUN) && !FREEZE;
    assign cpl_off  = cpl_idx - head;
    assign cpl_ok   = cpl_req && !FREEZE && (state == RUN) && ({1'b0, cpl_off} < count);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= RUN;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rel_valid   <= '0;
            rel_phys    <= '0;
            com_count   <= 3'd0;
            flush_out   <= 1'b0;
            copy_retrat <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fin_q[i] <= 1'b0;
                exc_q[i] <= 1'b0;
            end
            for (int i = 0; i < NARCH; i++) retrat[i] <= PHYS_AW'(i);
`ifdef ROB_COMMIT_STATS_EN
            stat_commits <= '0;
            stat_exc     <= '0;
`endif
        end else begin
            rel_valid   <= '0;
            rel_phys    <= '0;
            com_count   <= 3'd0;
            flush_out   <= 1'b0;
            copy_retrat <= 1'b0;
            if (!FREEZE) begin
                if (state == FLUSH) begin
                    state <= RUN;
                end else if (head_exc) begin
                    // Pointers collapse on entry so the FLUSH cycle already shows an empty ROB.
                    state       <= FLUSH;
                    head        <= '0;
                    tail        <= '0;
                    count       <= '0;
                    flush_out   <= 1'b1;
                    copy_retrat <= 1'b1;
`ifdef ROB_COMMIT_STATS_EN
                    if (stat_exc != '1) stat_exc <= stat_exc + 16'd1;
`endif
                end else begin
                    if (push_ok) begin
                        fin_q[tail]    <= 1'b0;
                        exc_q[tail]    <= 1'b0;
                        hasdst_q[tail] <= push_hasdst;
                        arch_q[tail]   <= push_arch;
                        newp_q[tail]   <= push_newp;
                        oldp_q[tail]   <= push_oldp;
                        tail           <= tail + 1'b1;
                    end
                    if (cpl_ok) begin
                        fin_q[cpl_idx] <= 1'b1;
                        if (cpl_exc) exc_q[cpl_idx] <= 1'b1;
                    end
                    // Later slots overwrite earlier ones on a shared architectural register.
                    for (int k = 0; k < COMMIT_WIDTH; k++) begin
                        if (retire[k] && hasdst_q[slot_idx[k]]) begin
                            retrat[arch_q[slot_idx[k]]]     <= newp_q[slot_idx[k]];
                            rel_valid[k]                    <= 1'b1;
                            rel_phys[k*PHYS_AW +: PHYS_AW]  <= oldp_q[slot_idx[k]];
                        end
                    end
                    com_count <= ret_n;
                    head      <= head + ROB_AW'(ret_n);
                    count     <= count + (ROB_AW+1)'(push_ok) - (ROB_AW+1)'(ret_n);
`ifdef ROB_COMMIT_STATS_EN
                    if (stat_commits > (32'hFFFF_FFFF - 32'(ret_n))) stat_commits <= '1;
                    else stat_commits <= stat_commits + 32'(ret_n);
`endif
                end
            end
        end
    end

endmodule
